// File: rtl/bcd_timer.sv
// MM:SS BCD up/down timer driven by a synchronised, edge-detected 1 Hz sec_clk.
// Digits are kept and updated individually so the outputs are always valid BCD.
module bcd_timer #(
    parameter int unsigned MAX_MIN     = 59,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sec_clk,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       load,
    input  logic       up_down,
    input  logic [7:0] load_min,
    input  logic [7:0] load_sec,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       running,
    output logic       done
);

    localparam logic [3:0] MAX_T = 4'(MAX_MIN / 10);
    localparam logic [3:0] MAX_U = 4'(MAX_MIN % 10);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t           state, state_nx;
    logic [SYNC_STAGES-1:0] sync_q;
    logic             edge_q;
    logic             tick;
    logic [3:0]       mt, mu, st, su;
    logic [3:0]       mt_nx, mu_nx, st_nx, su_nx;
    logic [3:0]       imt, imu, ist, isu;
    logic [3:0]       dmt, dmu, dst, dsu;
    logic             done_nx;
    logic [7:0]       pre_min, pre_sec;

    function automatic logic [7:0] sanitise(input logic [7:0] v, input logic [3:0] tmax);
        logic [3:0] t, u;
        t = (v[7:4] > tmax) ? tmax : v[7:4];
        u = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
        return {t, u};
    endfunction

    assign tick    = sync_q[SYNC_STAGES-1] & ~edge_q;
    assign min_bcd = {mt, mu};
    assign sec_bcd = {st, su};
    assign pre_min = sanitise(load_min, 4'd9);
    assign pre_sec = sanitise(load_sec, 4'd5);

    // Digit-wise increment with seconds->minutes carry; minutes wrap at 99.
    always_comb begin
        imt = mt;
        imu = mu;
        ist = st;
        isu = su;
        if (su != 4'd9) begin
            isu = su + 4'd1;
        end else begin
            isu = 4'd0;
            if (st != 4'd5) begin
                ist = st + 4'd1;
            end else begin
                ist = 4'd0;
                if (mu != 4'd9) begin
                    imu = mu + 4'd1;
                end else begin
                    imu = 4'd0;
                    imt = (mt == 4'd9) ? 4'd0 : mt + 4'd1;
                end
            end
        end
    end

    // Digit-wise decrement; only used when the count is not 00:00.
    always_comb begin
        dmt = mt;
        dmu = mu;
        dst = st;
        dsu = su;
        if (su != 4'd0) begin
            dsu = su - 4'd1;
        end else begin
            dsu = 4'd9;
            if (st != 4'd0) begin
                dst = st - 4'd1;
            end else begin
                dst = 4'd5;
                if (mu != 4'd0) begin
                    dmu = mu - 4'd1;
                end else begin
                    dmu = 4'd9;
                    dmt = (mt == 4'd0) ? 4'd0 : mt - 4'd1;
                end
            end
        end
    end

    always_comb begin
        state_nx = state;
        mt_nx    = mt;
        mu_nx    = mu;
        st_nx    = st;
        su_nx    = su;
        done_nx  = 1'b0;
        if (clear) begin
            state_nx = IDLE;
            mt_nx    = '0;
            mu_nx    = '0;
            st_nx    = '0;
            su_nx    = '0;
        end else if (load) begin
            state_nx = IDLE;
            {mt_nx, mu_nx} = pre_min;
            {st_nx, su_nx} = pre_sec;
        end else begin
            case (state)
                IDLE, PAUSE: begin
                    if (!stop && start) state_nx = RUN;
                end
                RUN: begin
                    if (stop) begin
                        state_nx = PAUSE;
                    end else if (tick) begin
                        if (up_down) begin
                            {mt_nx, mu_nx, st_nx, su_nx} = {imt, imu, ist, isu};
                            if ({imt, imu, ist, isu} == {MAX_T, MAX_U, 4'd5, 4'd9}) begin
                                state_nx = DONE;
                                done_nx  = 1'b1;
                            end
                        end else if ({mt, mu, st, su} == 16'h0000) begin
                            state_nx = DONE;
                            done_nx  = 1'b1;
                        end else begin
                            {mt_nx, mu_nx, st_nx, su_nx} = {dmt, dmu, dst, dsu};
                            if ({dmt, dmu, dst, dsu} == 16'h0000) begin
                                state_nx = DONE;
                                done_nx  = 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            edge_q  <= 1'b0;
            state   <= IDLE;
            mt      <= '0;
            mu      <= '0;
            st      <= '0;
            su      <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], sec_clk};
            edge_q  <= sync_q[SYNC_STAGES-1];
            state   <= state_nx;
            mt      <= mt_nx;
            mu      <= mu_nx;
            st      <= st_nx;
            su      <= su_nx;
            running <= (state_nx == RUN);
            done    <= done_nx;
        end
    end

endmodule

// File: tb/tb_bcd_timer.sv
// Directed bench for bcd_timer: preset sanitising table plus multi-cycle count sequences.
module tb_bcd_timer;

    logic       clk = 1'b0;
    logic       rst_n, sec_clk, start, stop, clear, load, up_down;
    logic [7:0] load_min, load_sec;
    logic [7:0] min_bcd, sec_bcd, min0, sec0;
    logic       running, done, running0, done0;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned done_cnt = 0, done0_cnt = 0, tick_cnt = 0;
    int unsigned base, base0;

    typedef struct {
        logic [7:0] lmin;
        logic [7:0] lsec;
        logic [7:0] emin;
        logic [7:0] esec;
    } vec_t;
    vec_t vecs[5];

    always #5 clk = ~clk;

    bcd_timer #(.MAX_MIN(59), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .sec_clk(sec_clk), .start(start), .stop(stop),
        .clear(clear), .load(load), .up_down(up_down), .load_min(load_min),
        .load_sec(load_sec), .min_bcd(min_bcd), .sec_bcd(sec_bcd),
        .running(running), .done(done)
    );

    bcd_timer #(.MAX_MIN(0), .SYNC_STAGES(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .sec_clk(sec_clk), .start(start), .stop(stop),
        .clear(clear), .load(load), .up_down(up_down), .load_min(load_min),
        .load_sec(load_sec), .min_bcd(min0), .sec_bcd(sec0),
        .running(running0), .done(done0)
    );

    always @(negedge clk) begin
        if (done)     done_cnt++;
        if (done0)    done0_cnt++;
        if (dut.tick) tick_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sec_edge();
        @(negedge clk);
        sec_clk = 1'b1;
        repeat (4) @(negedge clk);
        sec_clk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_load(input logic [7:0] m, input logic [7:0] s);
        @(negedge clk);
        load_min = m;
        load_sec = s;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'hAF, 8'h7C, 8'h99, 8'h59};
        vecs[1] = '{8'h12, 8'h34, 8'h12, 8'h34};
        vecs[2] = '{8'h0A, 8'h60, 8'h09, 8'h50};
        vecs[3] = '{8'hFF, 8'hFF, 8'h99, 8'h59};
        vecs[4] = '{8'h00, 8'h00, 8'h00, 8'h00};

        rst_n = 1'b0; sec_clk = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
        load = 1'b0; up_down = 1'b1; load_min = '0; load_sec = '0;
        repeat (3) @(negedge clk);
        chk("reset_min", 32'(min_bcd), 32'h00);
        chk("reset_sec", 32'(sec_bcd), 32'h00);
        chk("reset_running", 32'(running), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            pulse_load(vecs[i].lmin, vecs[i].lsec);
            chk($sformatf("load%0d_min", i), 32'(min_bcd), 32'(vecs[i].emin));
            chk($sformatf("load%0d_sec", i), 32'(sec_bcd), 32'(vecs[i].esec));
            chk($sformatf("load%0d_running", i), 32'(running), 32'h0);
        end

        // IDLE ignores ticks
        pulse_load(8'h00, 8'h09);
        sec_edge();
        chk("idle_tick_sec", 32'(sec_bcd), 32'h09);

        // Stop asserted in the cycle the tick is live: tick is dropped
        up_down = 1'b1;
        pulse_start();
        sec_edge();
        chk("run_to_0010", 32'({min_bcd, sec_bcd}), 32'h0010);
        @(negedge clk);
        sec_clk = 1'b1;
        @(negedge clk);
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        sec_clk = 1'b0;
        repeat (3) @(negedge clk);
        chk("stop_tick_count", 32'({min_bcd, sec_bcd}), 32'h0010);
        chk("stop_tick_running", 32'(running), 32'h0);
        repeat (5) sec_edge();
        chk("pause_hold", 32'({min_bcd, sec_bcd}), 32'h0010);
        pulse_start();
        chk("resume_running", 32'(running), 32'h1);
        sec_edge();
        chk("resume_count", 32'({min_bcd, sec_bcd}), 32'h0011);

        // Up count across a minute boundary
        pulse_clear();
        chk("clear_count", 32'({min_bcd, sec_bcd}), 32'h0000);
        chk("clear_running", 32'(running), 32'h0);
        base = done_cnt;
        up_down = 1'b1;
        pulse_start();
        repeat (65) sec_edge();
        chk("up65_count", 32'({min_bcd, sec_bcd}), 32'h0105);
        chk("up65_running", 32'(running), 32'h1);
        chk("up65_no_done", done_cnt - base, 0);

        // Down from 01:00 to terminal
        pulse_load(8'h01, 8'h00);
        base = done_cnt;
        up_down = 1'b0;
        pulse_start();
        repeat (60) sec_edge();
        chk("down60_count", 32'({min_bcd, sec_bcd}), 32'h0000);
        chk("down60_done_cycles", done_cnt - base, 1);
        chk("down60_running", 32'(running), 32'h0);
        repeat (3) sec_edge();
        pulse_start();
        sec_edge();
        chk("done_hold_count", 32'({min_bcd, sec_bcd}), 32'h0000);
        chk("done_hold_running", 32'(running), 32'h0);
        chk("done_hold_pulses", done_cnt - base, 1);

        // Down tick from a 00:00 preset terminates without wrapping
        pulse_clear();
        base = done_cnt;
        pulse_start();
        sec_edge();
        chk("zero_down_count", 32'({min_bcd, sec_bcd}), 32'h0000);
        chk("zero_down_done", done_cnt - base, 1);
        chk("zero_down_running", 32'(running), 32'h0);

        // MAX_MIN=0 instance reaches 00:59 terminal; default instance keeps running
        pulse_load(8'h00, 8'h58);
        base = done_cnt;
        base0 = done0_cnt;
        up_down = 1'b1;
        pulse_start();
        sec_edge();
        chk("max0_count", 32'({min0, sec0}), 32'h0059);
        chk("max0_done", done0_cnt - base0, 1);
        chk("max0_running", 32'(running0), 32'h0);
        chk("max59_count", 32'({min_bcd, sec_bcd}), 32'h0059);
        chk("max59_no_done", done_cnt - base, 0);
        pulse_clear();
        chk("max0_clear_count", 32'({min0, sec0}), 32'h0000);
        chk("max0_clear_done", 32'(done0), 32'h0);
        chk("max0_clear_running", 32'(running0), 32'h0);

        // Async reset mid-run, released with sec_clk already high
        pulse_load(8'h12, 8'h33);
        pulse_start();
        sec_edge();
        chk("pre_reset_count", 32'({min_bcd, sec_bcd}), 32'h1234);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_count", 32'({min_bcd, sec_bcd}), 32'h0000);
        chk("async_rst_running", 32'(running), 32'h0);
        chk("async_rst_done", 32'(done), 32'h0);
        sec_clk = 1'b1;
        repeat (2) @(negedge clk);
        base = tick_cnt;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("release_tick", tick_cnt - base, 1);
        chk("release_count", 32'({min_bcd, sec_bcd}), 32'h0000);
        chk("release_running", 32'(running), 32'h0);
        sec_clk = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
